imm_bus_arbiter: RTL and testbench
==================================

// Module: imm_bus_arbiter
// PURPOSE
//  Arbiter/sequencer for the multicycle CPU's shared internal tri-state bus. It grants the bus
//  to one driver at a time (PC, ALU, regfile, sign-extend unit, ...) and inserts turnaround gaps.
//  It also sequences the sign-extend unit: latches its ext-select, then raises its high/low output enables.
//  Sits between the main control FSM (requesters) and the bus drivers' output-enable pins.
// PARAMETERS
//  NREQ      4  number of bus requesters (>=2)
//  IMM_IDX   3  requester index owned by the sign-extend unit (< NREQ)
//  MAX_HOLD  8  max consecutive grant cycles before preemption if another req pending (>=1)
//  TURN_CYC  1  idle bus cycles between any two grants (>=1)
// PORTS
//  clk           in   1     single clock, all state on rising edge
//  rst           in   1     synchronous reset, active-high
//  req           in   NREQ  level request per driver; held until done
//  imm_sel_in    in   2     ext-select from control FSM (10=const 1, 11=26b zero-ext, else 16b sign-ext)
//  gnt           out  NREQ  one-hot registered grant = bus output enable for non-imm drivers
//  imm_extsel    out  2     ext-select latched at imm grant, to sign-extend unit
//  imm_oe_h      out  1     imm high-nibble output enable [31:28]
//  imm_oe_l      out  1     imm low 28-bit output enable [27:0]
//  bus_busy      out  1     1 while any gnt bit set
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, imm_extsel=2'b00, imm_oe_h=imm_oe_l=0, bus_busy=0, hold_cnt=0,
//   turn_cnt=0, rr_ptr=NREQ-1; rst has priority over every other event, incl. mid-grant (gnt drops next edge).
//  States: IDLE, GRANT, TURN (2-bit enum).
//  IDLE: req!=0 at edge t -> winner w chosen, gnt=onehot(w) from t+1, state GRANT, hold_cnt=0.
//  GRANT: hold_cnt saturates at MAX_HOLD-1.
//   - req[w]==0 -> gnt=0 next edge, state TURN.
//   - hold_cnt==MAX_HOLD-1 and (req & ~onehot(w))!=0 -> preempt: gnt=0, TURN.
//   - hold_cnt==MAX_HOLD-1, no other req -> keep grant indefinitely.
//   - req[w] low and other req same cycle -> drop still goes through TURN.
//  TURN: gnt=0 for exactly TURN_CYC cycles; at last TURN cycle, if req!=0 pick winner
//   (gnt on next edge), else IDLE. Never two grants without >=TURN_CYC zero cycles between.
//  Winner selection (see CONFIGURATION); rr_ptr updated to w when a grant is issued.
//  Sign-extend sequencing (w==IMM_IDX):
//   - imm_extsel <= imm_sel_in on the grant edge; held stable until next imm grant.
//   - gnt[IMM_IDX] stays 0; instead imm_oe_l=imm_oe_h=1 from one cycle after grant edge
//     (extsel setup cycle), deasserted on the same edge gnt would drop. Hold/preempt counts include setup cycle.
//   - imm req dropped during setup cycle -> OEs never rise; TURN as normal.
//  bus_busy = |gnt | imm grant active (incl. setup cycle).
//  Invariant: at most one of {gnt bits, imm_oe_*} active in any cycle.
// CONFIGURATION
//  RR_ARB_EN defined: round-robin, search starts at rr_ptr+1 mod NREQ, wraps.
//  RR_ARB_EN undefined: fixed priority, lowest index wins; rr_ptr unused (kept at reset value).
// STRUCTURE
//  Package bus_arb_pkg: state enum {IDLE,GRANT,TURN}, ext-select codes (EXT_SIGN16,
//   EXT_ONE=2'b10, EXT_ZERO26=2'b11), default IMM_IDX.
//  Sub-module rr_pick: combinational (req, start_ptr) -> onehot winner + index;
//   fixed priority = rr_pick with start_ptr=0. Top holds FSM, counters, imm OE logic.
// TESTING
//  1 rst high 3 cycles mid-grant (req=0001) -> gnt=0, oe_h/l=0, state IDLE next edge; no glitch.
//  2 req=0001 at t, dropped at t+3 -> gnt=0001 t+1..t+3, 0 at t+4 (TURN_CYC=1), IDLE t+5.
//  3 req=1000 (IMM_IDX=3), imm_sel_in=11 -> t+1 imm_extsel=11, oe=0; t+2 oe_h=oe_l=1; gnt stays 0.
//  4 req=0011 held forever, RR_ARB_EN -> grants alternate 0001/0010, each 8 cycles, 1-cycle gaps.
//  5 same as 4 without RR_ARB_EN -> 0001 kept indefinitely? no: preempt, then 0001 re-wins every time.
//  6 req=0110 simultaneous, rr_ptr=1, RR_ARB_EN -> 0100 granted first, then 0010 after drop+TURN.

Source files
------------

// File: rtl/imm_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg: shared types and constants for the immediate-aware bus arbiter.
//   arb_state_e     : arbiter FSM states (IDLE, GRANT, TURN)
//   ext_sel_e       : sign-extend unit select codes; any code other than
//                     EXT_ONE / EXT_ZERO26 selects 16-bit sign extension
//   DEFAULT_IMM_IDX : requester index normally owned by the sign-extend unit
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } arb_state_e;

    typedef enum logic [1:0] {
        EXT_SIGN16 = 2'b00,
        EXT_ONE    = 2'b10,
        EXT_ZERO26 = 2'b11
    } ext_sel_e;

    localparam int unsigned DEFAULT_IMM_IDX = 3;

endpackage

// File: rtl/imm_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// imm_bus_arbiter_if: request/grant bundle between the control FSM, the arbiter
// and the bus drivers' output enables.
//   req        : level request per driver, held until done
//   imm_sel_in : ext-select from the control FSM
//   gnt        : one-hot grant, output enable for non-immediate drivers
//   imm_extsel : ext-select latched at immediate grant
//   imm_oe_h   : immediate output enable, bits [31:28]
//   imm_oe_l   : immediate output enable, bits [27:0]
//   bus_busy   : bus currently owned (including immediate setup cycle)
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface imm_bus_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [1:0]      imm_sel_in;
    logic [NREQ-1:0] gnt;
    logic [1:0]      imm_extsel;
    logic            imm_oe_h;
    logic            imm_oe_l;
    logic            bus_busy;

    modport master (
        output req, imm_sel_in,
        input  gnt, imm_extsel, imm_oe_h, imm_oe_l, bus_busy
    );

    modport slave (
        input  req, imm_sel_in,
        output gnt, imm_extsel, imm_oe_h, imm_oe_l, bus_busy
    );
endinterface

// File: rtl/imm_bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick: combinational circular priority picker.
//   req_i    : request vector
//   start_i  : index searched first; search proceeds upward and wraps
//   onehot_o : one-hot winner (zero when no request)
//   idx_o    : winner index
//   valid_o  : at least one request present
// Fixed priority is this picker with start_i tied to zero.
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   start_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);
    always_comb begin
        logic        found;
        int unsigned j;
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        j        = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = i + 32'(start_i);
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req_i[j]) begin
                found    = 1'b1;
                idx_o    = IW'(j);
                onehot_o = NREQ'(1) << j;
            end
        end
        valid_o = found;
    end
endmodule

// File: rtl/imm_bus_arbiter.sv
// -----------------------------------------------------------------------------
// imm_bus_arbiter: grants the shared internal tri-state bus to one driver at a
// time, enforces TURN_CYC idle cycles between grants, preempts after MAX_HOLD
// cycles when someone else is waiting, and sequences the sign-extend unit
// (latch ext-select on grant, raise its output enables one cycle later).
// Ports:
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : imm_bus_arbiter_if.slave (req, imm_sel_in in; gnt, imm_extsel,
//         imm_oe_h, imm_oe_l, bus_busy out)
// Build option: RR_ARB_EN selects round-robin arbitration starting after the
// last winner; without it the lowest requesting index wins.
// -----------------------------------------------------------------------------
module imm_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IMM_IDX  = DEFAULT_IMM_IDX,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic               clk,
    input  logic               rst,
    imm_bus_arbiter_if.slave   bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned TW = $clog2(TURN_CYC + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
    localparam logic [IW-1:0] IMM_SEL   = IW'(IMM_IDX);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   win_q, win_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   turn_q, turn_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            oe_q, oe_d;
    logic [1:0]      extsel_q, extsel_d;
    logic            busy_q, busy_d;

    logic [IW-1:0]   start_ptr;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            others_pending;
    logic            issue;

`ifdef RR_ARB_EN
    localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    assign start_ptr = (rr_ptr_q == PTR_RST) ? '0 : rr_ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= PTR_RST;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = pick_idx;
        end
    end
`else
    assign start_ptr = '0;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i    (bus.req),
        .start_i  (start_ptr),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    assign others_pending = (bus.req & ~(NREQ'(1) << win_q)) != '0;

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        hold_d   = hold_q;
        turn_d   = turn_q;
        gnt_d    = gnt_q;
        oe_d     = oe_q;
        extsel_d = extsel_q;
        busy_d   = busy_q;
        issue    = 1'b0;

        unique case (state_q)
            IDLE: begin
                issue = pick_valid;
            end
            GRANT: begin
                if (!bus.req[win_q] || (hold_q == HOLD_LAST && others_pending)) begin
                    state_d = TURN;
                    turn_d  = '0;
                    gnt_d   = '0;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + 1'b1;
                    end
                    // First immediate grant cycle is the ext-select setup cycle.
                    if (win_q == IMM_SEL) begin
                        oe_d = 1'b1;
                    end
                end
            end
            TURN: begin
                if (turn_q == TURN_LAST) begin
                    if (pick_valid) begin
                        issue = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            state_d = GRANT;
            win_d   = pick_idx;
            hold_d  = '0;
            busy_d  = 1'b1;
            oe_d    = 1'b0;
            if (pick_idx == IMM_SEL) begin
                // Sign-extend unit never sees gnt; it is driven through its OEs.
                gnt_d    = '0;
                extsel_d = bus.imm_sel_in;
            end else begin
                gnt_d = pick_onehot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            win_q    <= '0;
            hold_q   <= '0;
            turn_q   <= '0;
            gnt_q    <= '0;
            oe_q     <= 1'b0;
            extsel_q <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            hold_q   <= hold_d;
            turn_q   <= turn_d;
            gnt_q    <= gnt_d;
            oe_q     <= oe_d;
            extsel_q <= extsel_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.imm_oe_h   = oe_q;
    assign bus.imm_oe_l   = oe_q;
    assign bus.imm_extsel = extsel_q;
    assign bus.bus_busy   = busy_q;

endmodule

// File: tb/tb_imm_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imm_bus_arbiter: scenario bench for imm_bus_arbiter (NREQ=4, IMM_IDX=3,
// MAX_HOLD=8, TURN_CYC=1). Each scenario pushes the expected outputs for every
// cycle into a queue, then drives the stimulus and pops one entry per edge.
// Expectations follow RR_ARB_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_imm_bus_arbiter;
    import bus_arb_pkg::*;

`ifdef RR_ARB_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] gnt;
        logic       oe_h;
        logic       oe_l;
        logic       busy;
        logic [1:0] ext;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    obs_t exp_q[$];

    imm_bus_arbiter_if #(.NREQ(4)) bus_if ();

    imm_bus_arbiter #(
        .NREQ     (4),
        .IMM_IDX  (3),
        .MAX_HOLD (8),
        .TURN_CYC (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic [3:0] g, logic oe, logic busy, logic [1:0] ext);
        obs_t r;
        r.gnt  = g;
        r.oe_h = oe;
        r.oe_l = oe;
        r.busy = busy;
        r.ext  = ext;
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t r;
        r.gnt  = bus_if.gnt;
        r.oe_h = bus_if.imm_oe_h;
        r.oe_l = bus_if.imm_oe_l;
        r.busy = bus_if.bus_busy;
        r.ext  = bus_if.imm_extsel;
        return r;
    endfunction

    // Drive one cycle of inputs, then land just after the edge that samples them.
    task automatic cycle(input logic r, input logic [3:0] q, input logic [1:0] s);
        @(negedge clk);
        rst               = r;
        bus_if.req        = q;
        bus_if.imm_sel_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_q.delete();
        cycle(1'b1, 4'b0000, 2'b00);
        cycle(1'b1, 4'b0000, 2'b00);
    endtask

    task automatic test_reset();
        logic       rs[13];
        logic [3:0] rq[13];
        logic [1:0] sl[13];
        obs_t       e, g;
        rs = '{1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0};
        rq = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};
        sl = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 3, 3, 0};
        exp_q.delete();
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h1, 0, 1, 2'b00));
        exp_q.push_back(mk(4'h1, 0, 1, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h1, 0, 1, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 1, EXT_ZERO26));
        exp_q.push_back(mk(4'h0, 1, 1, EXT_ZERO26));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        for (int k = 0; k < 13; k++) begin
            cycle(rs[k], rq[k], sl[k]);
            e = exp_q.pop_front();
            g = sample();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL reset[%0d]: got %b required %b", k, g, e);
            end
        end
    endtask

    task automatic test_drop();
        logic [3:0] rq[10];
        obs_t       e, g;
        do_reset();
        rq = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h0};
        exp_q.push_back(mk(4'h1, 0, 1, 2'b00));
        exp_q.push_back(mk(4'h1, 0, 1, 2'b00));
        exp_q.push_back(mk(4'h1, 0, 1, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h1, 0, 1, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h2, 0, 1, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, rq[k], 2'b00);
            e = exp_q.pop_front();
            g = sample();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL drop[%0d]: got %b required %b", k, g, e);
            end
        end
    endtask

    task automatic test_imm();
        logic [3:0] rq[20];
        logic [1:0] sl[20];
        obs_t       e, g;
        do_reset();
        rq = '{4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 4'h9,
               4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h0, 4'h0};
        sl = '{3, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_q.push_back(mk(4'h0, 0, 1, EXT_ZERO26));
        exp_q.push_back(mk(4'h0, 1, 1, EXT_ZERO26));
        exp_q.push_back(mk(4'h0, 1, 1, EXT_ZERO26));
        exp_q.push_back(mk(4'h0, 0, 0, EXT_ZERO26));
        exp_q.push_back(mk(4'h0, 0, 0, EXT_ZERO26));
        // Request withdrawn during setup: enables must never rise.
        exp_q.push_back(mk(4'h0, 0, 1, EXT_ONE));
        exp_q.push_back(mk(4'h0, 0, 0, EXT_ONE));
        exp_q.push_back(mk(4'h0, 0, 0, EXT_ONE));
        // Setup cycle counts toward the 8-cycle hold limit.
        exp_q.push_back(mk(4'h0, 0, 1, 2'b01));
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back(mk(4'h0, 1, 1, 2'b01));
        end
        exp_q.push_back(mk(4'h0, 0, 0, 2'b01));
        exp_q.push_back(mk(4'h1, 0, 1, 2'b01));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b01));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b01));
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, rq[k], sl[k]);
            e = exp_q.pop_front();
            g = sample();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL imm[%0d]: got %b required %b", k, g, e);
            end
            total++;
            if ((g.gnt != 4'h0) && (g.oe_h || g.oe_l)) begin
                bad++;
                $display("FAIL imm_exclusive[%0d]: gnt=%b oe_h=%b oe_l=%b required no overlap",
                         k, g.gnt, g.oe_h, g.oe_l);
            end
        end
    endtask

    task automatic test_hold();
        obs_t e, g;
        int   n, p;
        do_reset();
        for (int k = 0; k < 36; k++) begin
            p = k % 9;
            n = k / 9;
            if (p == 8) begin
                exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
            end else if (RR && (n % 2 == 1)) begin
                exp_q.push_back(mk(4'h2, 0, 1, 2'b00));
            end else begin
                exp_q.push_back(mk(4'h1, 0, 1, 2'b00));
            end
        end
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        for (int k = 0; k < 37; k++) begin
            cycle(1'b0, (k < 36) ? 4'b0011 : 4'b0000, 2'b00);
            e = exp_q.pop_front();
            g = sample();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL hold[%0d]: got %b required %b", k, g, e);
            end
        end
    endtask

    task automatic test_rr_order();
        logic [3:0] w1, w2;
        logic [3:0] rq[9];
        obs_t       e, g;
        do_reset();
        w1 = RR ? 4'b0100 : 4'b0010;
        w2 = RR ? 4'b0010 : 4'b0100;
        rq = '{4'h2, 4'h0, 4'h0, 4'h6, 4'h6, 4'h6 & ~w1, 4'h6 & ~w1, 4'h0, 4'h0};
        exp_q.push_back(mk(4'h2, 0, 1, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(w1, 0, 1, 2'b00));
        exp_q.push_back(mk(w1, 0, 1, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(w2, 0, 1, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        exp_q.push_back(mk(4'h0, 0, 0, 2'b00));
        for (int k = 0; k < 9; k++) begin
            cycle(1'b0, rq[k], 2'b00);
            e = exp_q.pop_front();
            g = sample();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL rr_order[%0d]: got %b required %b", k, g, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus_if.req        = '0;
        bus_if.imm_sel_in = 2'b00;
        test_reset();
        test_drop();
        test_imm();
        test_hold();
        test_rr_order();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
